mux2to1_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 2:1 mux datapath.
- Grants one requester at a time and drives the mux select.
- Registers the selected data bit with a valid flag.
- Bounds each grant to MAX_HOLD cycles so that neither requester can starve the other.
- Sits between two producers (i0 side, i1 side) and the single downstream consumer of the mux output.

---
 rtl/mux2to1_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux2to1_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2to1_arbiter.sv
// ============================================================================
// Module   : mux2to1_arbiter
// Brief    : Two-port round-robin arbiter with a bounded hold time. It drives
//            the 2:1 mux select and registers the selected data bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2to1_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              grant0,
  output logic              grant1,
  output logic              select,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_g0   = 2'd1;
  localparam logic [1:0] c_st_g1   = 2'd2;

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic              r_prio;
  logic              r_grant0;
  logic              r_grant1;
  logic              r_select;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic [1:0]        w_next_state;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_next_prio;
  logic              w_next_sel;
  logic              w_next_busy;
  logic              w_entering;
  logic [CNT_W-1:0]  w_cnt_inc;

  // The counter keeps counting while the owner is alone, so a late contender
  // meets a saturated count and wins on the very next edge.
  assign w_cnt_inc = (r_hold_cnt == c_hold_last) ? r_hold_cnt : r_hold_cnt + c_cnt_one;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (req0 && req1) begin
          w_next_state = r_prio ? c_st_g1 : c_st_g0;
        end else if (req0) begin
          w_next_state = c_st_g0;
        end else if (req1) begin
          w_next_state = c_st_g1;
        end
      end
      c_st_g0: begin
        if (!req0) begin
          w_next_state = req1 ? c_st_g1 : c_st_idle;
        end else if (req1 && (r_hold_cnt == c_hold_last)) begin
          w_next_state = c_st_g1;
        end
      end
      c_st_g1: begin
        if (!req1) begin
          w_next_state = req0 ? c_st_g0 : c_st_idle;
        end else if (req0 && (r_hold_cnt == c_hold_last)) begin
          w_next_state = c_st_g0;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  assign w_next_busy = (w_next_state != c_st_idle);
  assign w_entering  = w_next_busy && (w_next_state != r_state);

  always_comb begin
    w_next_cnt  = r_hold_cnt;
    w_next_prio = r_prio;
    if (w_entering) begin
      w_next_cnt  = '0;
      // Favour whichever port did not just win.
      w_next_prio = (w_next_state == c_st_g0);
    end else if (w_next_busy) begin
      w_next_cnt  = w_cnt_inc;
    end
  end

  always_comb begin
    w_next_sel = r_select;
    if (w_next_state == c_st_g0) begin
      w_next_sel = 1'b0;
    end else if (w_next_state == c_st_g1) begin
      w_next_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_hold_cnt   <= '0;
      r_prio       <= 1'b0;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
      r_select     <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_hold_cnt   <= w_next_cnt;
      r_prio       <= w_next_prio;
      r_grant0     <= (w_next_state == c_st_g0);
      r_grant1     <= (w_next_state == c_st_g1);
      r_select     <= w_next_sel;
      r_dout_valid <= w_next_busy;
      if (w_next_busy) begin
        r_dout <= w_next_sel ? d1 : d0;
      end
    end
  end

  assign grant0     = r_grant0;
  assign grant1     = r_grant1;
  assign select     = r_select;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux2to1_arbiter.sv
// ============================================================================
// Module   : tb_mux2to1_arbiter
// Brief    : Self-checking bench for mux2to1_arbiter using an ownership model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2to1_arbiter;

  localparam int DW       = 1;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
  logic          grant0;
  logic          grant1;
  logic          select;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  mux2to1_arbiter #(.DATA_W(DW), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .grant0(grant0), .grant1(grant1), .select(select), .dout(dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (nobody), 0 or 1; held = cycles of the current grant.
  int            m_own = -1;
  int            m_held = 0;
  int            m_fav = 0;
  logic          m_sel = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0;
  int            m_nw;

  function automatic int next_owner(input int own, input int held, input int fav,
                                    input logic r0, input logic r1);
    logic r [2];
    r[0] = r0;
    r[1] = r1;
    if (own < 0) begin
      if (r0 && r1) return fav;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    if (!r[own]) return r[1-own] ? 1 - own : -1;
    if (r[1-own] && held >= MAX_HOLD) return 1 - own;
    return own;
  endfunction

  always_comb m_nw = next_owner(m_own, m_held, m_fav, req0, req1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own   <= -1;
      m_held  <= 0;
      m_fav   <= 0;
      m_sel   <= 1'b0;
      m_dout  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_own <= m_nw;
      if (m_nw >= 0) begin
        if (m_nw != m_own) begin
          m_held <= 1;
          m_fav  <= 1 - m_nw;
        end else begin
          m_held <= m_held + 1;
        end
        m_sel   <= (m_nw == 1);
        m_dout  <= (m_nw == 1) ? d1 : d0;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Contended samples seen within the current grant.
  int c_run = 0;
  int c_owner = 0;

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("grant0", grant0, (m_own == 0));
      chk("grant1", grant1, (m_own == 1));
      chk("select", select, m_sel);
      chk("dout", dout, m_dout);
      chk("dout_valid", dout_valid, m_valid);
      chk("grant_onehot", (grant0 && grant1), 1'b0);
      chk("contend_bound", (c_run <= MAX_HOLD), 1'b1);
    end
  end

  always @(negedge clk) begin
    int now_own;
    logic other;
    now_own = grant1 ? 2 : (grant0 ? 1 : 0);
    other   = grant1 ? req0 : req1;
    c_owner <= now_own;
    if (now_own == 0 || now_own != c_owner) begin
      c_run <= (now_own != 0 && other) ? 1 : 0;
    end else if (other) begin
      c_run <= c_run + 1;
    end
  end

  task automatic step(input logic r0, input logic r1, input logic [DW-1:0] x0,
                      input logic [DW-1:0] x1);
    req0 = r0;
    req1 = r1;
    d0   = x0;
    d1   = x1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #3;
    chk("rst_grant0", grant0, 1'b0);
    chk("rst_grant1", grant1, 1'b0);
    chk("rst_select", select, 1'b0);
    chk("rst_dout", dout, '0);
    chk("rst_valid", dout_valid, 1'b0);
    #9;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", dout_valid, 1'b0);

    // Single requester never preempted.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("solo_grant0", grant0, 1'b1);
      chk("solo_dout", dout, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("solo_release", grant0, 1'b0);
    chk("solo_dout_hold", dout, 1'b1);

    // Contention from reset: 4 cycles each, alternating.
    reset_pulse();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("rr_grant1", grant1, ((i / 4) % 2));
      chk("rr_grant0", grant0, ((i / 4) % 2 == 0));
      chk("rr_dout", dout, ((i / 4) % 2));
    end

    // Handoff without IDLE bubble.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ho_g0", grant0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ho_g1", grant1, 1'b1);
    chk("ho_valid", dout_valid, 1'b1);
    chk("ho_dout", dout, 1'b1);

    // Priority after G1 released: port 0 is favoured.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_g0", grant0, 1'b1);
    chk("prio_dout", dout, 1'b1);

    // Reset asserted mid-G1, between edges.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_g1", grant1, 1'b1);
    reset_pulse();
    chk("midrst_grant1", grant1, 1'b0);
    chk("midrst_select", select, 1'b0);
    chk("midrst_valid", dout_valid, 1'b0);
    chk("midrst_dout", dout, '0);
    req0  = 1'b0;
    req1  = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("postrst_g0", grant0, 1'b0);
    chk("postrst_g1", grant1, 1'b0);

    // Randomised traffic, requests biased high to create contention.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           DW'($urandom), DW'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
